// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch stage: PC, 1-cycle imem requests and a small
// {pc, instr} FIFO feeding decode, with branch redirect and squash.
module fetch_unit #(
    parameter int          N        = 64,
    parameter int          DEPTH    = 2,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         br_taken_i,
    input  logic [N-1:0] br_target_i,
    input  logic         halt_i,
    output logic         imem_req_o,
    output logic [N-1:0] imem_addr_o,
    input  logic [31:0]  imem_rdata_i,
    output logic [31:0]  instr_o,
    output logic [N-1:0] pc_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic         align_err_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] FULL = (CW + 1)'(DEPTH);
    localparam logic [N-1:0] STEP = N'(4);

    logic [N-1:0]  pc;
    logic [N-1:0]  inflight_pc;
    logic          inflight;
    logic          squash;
    logic          align_err;

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [N-1:0]  pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   occ;

    assign valid_o = (count != '0) & !br_taken_i;
    assign pop     = valid_o & ready_i;

    // A redirect flushes the buffer, so a same-cycle return is never kept.
    assign push = inflight & !squash & !br_taken_i;

    // Occupancy seen by the issue check credits a pop made this cycle.
    assign occ = {1'b0, count}
               + {{CW{1'b0}}, inflight}
               - {{CW{1'b0}}, pop};

    assign issue = reset & !halt_i & !br_taken_i & (occ < FULL);

    assign imem_req_o  = issue;
    assign imem_addr_o = pc;
    assign instr_o     = instr_mem[rd_ptr];
    assign pc_o        = pc_mem[rd_ptr];
    assign align_err_o = align_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            squash      <= 1'b0;
            align_err   <= 1'b0;
        end else begin
            if (br_taken_i) begin
                pc <= {br_target_i[N-1:2], 2'b00};
            end else if (issue) begin
                pc <= pc + STEP;
            end
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
            end
            squash <= br_taken_i & inflight;
            if (br_taken_i) begin
                align_err <= align_err | (br_target_i[1:0] != 2'b00);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (br_taken_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]    <= inflight_pc;
            instr_mem[wr_ptr] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order stream scoreboard with a sequential-PC
// reference model, directed latency/backpressure/redirect cases and random traffic.
module tb_fetch_unit;

    localparam logic [63:0] RPC  = 64'h100;
    localparam logic [63:0] WRAP = 64'hFFFF_FFFF_FFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        br_taken = 1'b0;
    logic [63:0] br_target = '0;
    logic        halt = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        valid;
    logic        ready = 1'b0;
    logic        align_err;

    int n_checks = 0;
    int n_fail = 0;
    int n_acc = 0;
    logic [63:0] exp_q[$];

    fetch_unit #(.N(64), .DEPTH(2), .RESET_PC(RPC)) dut (
        .clk(clk),
        .reset(reset),
        .br_taken_i(br_taken),
        .br_target_i(br_target),
        .halt_i(halt),
        .imem_req_o(imem_req),
        .imem_addr_o(imem_addr),
        .imem_rdata_i(imem_rdata),
        .instr_o(instr),
        .pc_o(pc),
        .valid_o(valid),
        .ready_i(ready),
        .align_err_o(align_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ 32'hABC;
    endfunction

    // Synchronous instruction memory, one cycle read latency.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? word_of(imem_addr) : $urandom;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected delivery order: consecutive words from the start address.
    task automatic seed(input logic [63:0] start);
        exp_q.delete();
        for (int i = 0; i < 512; i++) begin
            exp_q.push_back(start + 64'(4 * i));
        end
    endtask

    task automatic tick(input bit r, input bit h, input bit b,
                        input logic [63:0] t);
        @(negedge clk);
        ready = r;
        halt = h;
        br_taken = b;
        br_target = t;
        if (b) seed({t[63:2], 2'b00});
        #2;
    endtask

    task automatic release_and_stream();
        @(negedge clk);
        reset = 1'b1;
        ready = 1'b1;
        halt = 1'b0;
        br_taken = 1'b0;
        seed(RPC);
        #2;
        chk("c0_req", imem_req, 1);
        chk("c0_addr", imem_addr, RPC);
        chk("c0_valid", valid, 0);
        tick(1, 0, 0, 0);
        chk("c1_valid", valid, 0);
        tick(1, 0, 0, 0);
        chk("c2_valid", valid, 1);
        chk("c2_pc", pc, RPC);
    endtask

    always begin
        @(negedge clk);
        #3;
        if (reset && valid && ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", pc, e);
                chk("sb_instr", instr, word_of(e));
                n_acc++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        bit found;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", pc, 0);
        chk("rst_align", align_err, 0);
        chk("rst_addr", imem_addr, RPC);

        release_and_stream();

        tick(0, 0, 0, 0);
        for (int i = 4; i <= 8; i++) begin
            tick(0, 0, 0, 0);
            chk("bp_req", imem_req, 0);
            chk("bp_valid", valid, 1);
            chk("bp_head", pc, 64'h104);
            chk("bp_addr", imem_addr, 64'h10C);
        end
        tick(1, 0, 0, 0);
        chk("bp_credit_req", imem_req, 1);
        for (int i = 0; i < 10; i++) begin
            tick(1, 0, 0, 0);
            chk("tput_valid", valid, 1);
        end

        tick(1, 0, 1, 64'h2000);
        chk("br_valid", valid, 0);
        chk("br_req", imem_req, 0);
        tick(1, 0, 0, 0);
        chk("br1_req", imem_req, 1);
        chk("br1_addr", imem_addr, 64'h2000);
        chk("br1_valid", valid, 0);
        tick(1, 0, 0, 0);
        chk("br2_valid", valid, 0);
        tick(1, 0, 0, 0);
        chk("br3_valid", valid, 1);
        chk("br3_pc", pc, 64'h2000);
        repeat (5) tick(1, 0, 0, 0);

        chk("al_before", align_err, 0);
        tick(1, 0, 1, 64'h2002);
        tick(1, 0, 0, 0);
        chk("al_set", align_err, 1);
        chk("al_addr", imem_addr, 64'h2000);
        repeat (6) tick(1, 0, 0, 0);
        chk("al_sticky", align_err, 1);

        tick(1, 0, 1, WRAP);
        repeat (3) tick(1, 0, 0, 0);
        chk("wr_pc0", pc, WRAP);
        tick(1, 0, 0, 0);
        chk("wr_pc1", pc, WRAP + 64'd4);
        tick(1, 0, 0, 0);
        chk("wr_pc2", pc, 64'h0);

        for (int i = 0; i < 5; i++) begin
            tick(1, 1, 0, 0);
            chk("hlt_req", imem_req, 0);
            chk("hlt_valid", valid, (i < 2) ? 1 : 0);
        end
        tick(1, 0, 0, 0);
        chk("hlt_resume_req", imem_req, 1);
        repeat (6) tick(1, 0, 0, 0);
        chk("al_sticky2", align_err, 1);

        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid", valid, 0);
        chk("ar_req", imem_req, 0);
        chk("ar_align", align_err, 0);
        chk("ar_addr", imem_addr, RPC);
        repeat (3) @(negedge clk);
        release_and_stream();
        repeat (5) tick(1, 0, 0, 0);

        acc0 = n_acc;
        for (int i = 0; i < 300; i++) begin
            logic [63:0] t;
            bit b;
            t = {32'h0, $urandom} & ~64'h3;
            if ($urandom_range(0, 7) == 0) t = WRAP - 64'(4 * $urandom_range(0, 3));
            b = ($urandom_range(0, 19) == 0);
            tick($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, b, t);
        end
        chk("rnd_progress", (n_acc > acc0 + 50) ? 1 : 0, 1);

        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick(1, 0, 0, 0);
            if (valid) found = 1;
        end
        chk("live_valid", found, 1);
        chk("rnd_align", align_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
